// File: rtl/store_size_rmw.sv
// Store-size unit: byte/half stores do a read-modify-write of the memory word, word stores write directly.
// Latency: word store done in cycle 2, byte/half done in cycle MEM_LAT+3 (cycle 0 = start sampled).
// Backpressure: none queued; start is only accepted in IDLE, busy flags the unit as occupied.
// Optional lane selection / alignment check: define STORE_SIZE_LANE_EN.
module store_size_rmw #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  store_ctrl,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rd_data,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wr_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, DONE} state_t;

  localparam logic [1:0] LAT = 2'(MEM_LAT);

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  cnt;
  logic        half_q;
  logic [15:0] data_q;
  logic [31:0] merge_q;
  logic [31:0] merged;
  logic        is_word;
  logic        is_half;
  logic        misalign;

  // Word size dominates; 01 selects half, 00 selects byte.
  assign is_word = store_ctrl[1];
  assign is_half = ~store_ctrl[1] & store_ctrl[0];

`ifdef STORE_SIZE_LANE_EN
  logic [1:0] lane_q;
  logic       err_q;

  // Alignment is judged on the incoming request so a bad access can skip straight to DONE.
  always_comb begin
    misalign = 1'b0;
    if (is_word) misalign = |addr[1:0];
    else if (is_half) misalign = addr[0];
  end

  // Replace the addressed lane of the read word with the low-order store bits.
  always_comb begin
    merged = mem_rd_data;
    if (half_q) begin
      if (lane_q[1]) merged[31:16] = data_q;
      else           merged[15:0]  = data_q;
    end else begin
      case (lane_q)
        2'd0:    merged[7:0]   = data_q[7:0];
        2'd1:    merged[15:8]  = data_q[7:0];
        2'd2:    merged[23:16] = data_q[7:0];
        default: merged[31:24] = data_q[7:0];
      endcase
    end
  end
`else
  // Without lane selection every address is accepted as-is.
  always_comb begin
    misalign = 1'b0;
  end

  // Sub-word data always lands in the low lane of the read word.
  always_comb begin
    merged = mem_rd_data;
    if (half_q) merged[15:0] = data_q;
    else        merged[7:0]  = data_q[7:0];
  end
`endif

  // State register; reset forces IDLE at once, which also drops mem_wr combinationally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    mem_wr    = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (misalign)     state_nxt = DONE;
          else if (is_word) state_nxt = WRITE;
          else              state_nxt = READ;
        end
      end
      READ:  if (cnt == 2'd1) state_nxt = MERGE;
      MERGE: state_nxt = WRITE;
      WRITE: begin
        mem_wr    = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
`ifdef STORE_SIZE_LANE_EN
        err       = err_q;
`endif
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, latency counter and merge register; all hold their values in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr <= 32'd0;
      half_q   <= 1'b0;
      data_q   <= 16'd0;
      merge_q  <= 32'd0;
      cnt      <= 2'd0;
`ifdef STORE_SIZE_LANE_EN
      lane_q   <= 2'd0;
      err_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
`ifdef STORE_SIZE_LANE_EN
            mem_addr <= {addr[31:2], 2'b00};
            lane_q   <= addr[1:0];
            err_q    <= misalign;
`else
            mem_addr <= addr;
`endif
            half_q   <= is_half;
            data_q   <= store_data[15:0];
            if (!is_word) cnt <= LAT;
            if (is_word && !misalign) merge_q <= store_data;
          end
        end
        READ:    cnt     <= cnt - 2'd1;
        MERGE:   merge_q <= merged;
        default: ;
      endcase
    end
  end

  assign mem_wr_data = merge_q;

endmodule
